// File: rtl/box_pkg.sv
// Shared definitions for the box rasteriser: FSM states, draw modes and
// the default visible screen size of the VGA adapter.
package box_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } box_state_e;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  localparam int DEFAULT_SCREEN_W = 160;
  localparam int DEFAULT_SCREEN_H = 120;

endpackage

// File: rtl/box_drawer_raster_scanner.sv
// Row-major offset walker for a w x h box: one scan position per enabled
// cycle, flagging the final position and positions on the box border.
module raster_scanner #(
  parameter int SIZE_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              enable,
  input  logic [SIZE_W-1:0] w,
  input  logic [SIZE_W-1:0] h,
  output logic [SIZE_W-1:0] ox,
  output logic [SIZE_W-1:0] oy,
  output logic              last,
  output logic              border
);

  localparam logic [SIZE_W-1:0] ONE = SIZE_W'(1);

  logic [SIZE_W-1:0] ox_reg;
  logic [SIZE_W-1:0] oy_reg;
  logic [SIZE_W-1:0] w_last;
  logic [SIZE_W-1:0] h_last;
  logic              row_end;
  logic              col_end;

  assign w_last  = w - ONE;
  assign h_last  = h - ONE;
  assign row_end = (ox_reg == w_last);
  assign col_end = (oy_reg == h_last);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ox_reg <= '0;
      oy_reg <= '0;
    end else if (load) begin
      ox_reg <= '0;
      oy_reg <= '0;
    end else if (enable) begin
      if (row_end) begin
        ox_reg <= '0;
        // Wrap the row counter on the final position so a stray enable
        // never walks past the box.
        oy_reg <= col_end ? '0 : oy_reg + ONE;
      end else begin
        ox_reg <= ox_reg + ONE;
      end
    end
  end

  assign ox     = ox_reg;
  assign oy     = oy_reg;
  assign last   = row_end && col_end;
  assign border = (ox_reg == '0) || row_end || (oy_reg == '0) || col_end;

endmodule

// File: rtl/box_drawer.sv
// Rectangle rasteriser: latches a box request, walks it one pixel per clock
// and drives the VGA adapter write port with clipped, registered pixels.
module box_drawer
  import box_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int SIZE_W   = 4,
  parameter int SCREEN_W = DEFAULT_SCREEN_W,
  parameter int SCREEN_H = DEFAULT_SCREEN_H
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [X_W-1:0]    x_in,
  input  logic [Y_W-1:0]    y_in,
  input  logic [C_W-1:0]    colour_in,
  input  logic [SIZE_W-1:0] width_in,
  input  logic [SIZE_W-1:0] height_in,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              plot,
  output logic [X_W-1:0]    out_x,
  output logic [Y_W-1:0]    out_y,
  output logic [C_W-1:0]    out_colour
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_DRAW = DRAW;
  localparam logic [1:0] S_DONE = DONE;

  // One extra bit so a box hanging off the right/bottom edge is clipped
  // rather than wrapping back onto column/row 0.
  localparam int PX_W = X_W + 1;
  localparam int PY_W = Y_W + 1;
  localparam logic [PX_W-1:0] SCREEN_W_L = PX_W'(SCREEN_W);
  localparam logic [PY_W-1:0] SCREEN_H_L = PY_W'(SCREEN_H);

  logic [1:0]        state_reg;
  logic [X_W-1:0]    x_reg;
  logic [Y_W-1:0]    y_reg;
  logic [C_W-1:0]    colour_reg;
  logic [SIZE_W-1:0] w_reg;
  logic [SIZE_W-1:0] h_reg;
  logic              mode_reg;

  logic              busy_reg;
  logic              done_reg;
  logic              plot_reg;
  logic [X_W-1:0]    out_x_reg;
  logic [Y_W-1:0]    out_y_reg;
  logic [C_W-1:0]    out_colour_reg;

  logic              accept;
  logic              empty_req;
  logic              scan_load;
  logic              scan_enable;
  logic [SIZE_W-1:0] ox;
  logic [SIZE_W-1:0] oy;
  logic              scan_last;
  logic              scan_border;
  logic [PX_W-1:0]   px;
  logic [PY_W-1:0]   py;
  logic              pix_en;

  assign accept      = (state_reg == S_IDLE) && start;
  assign empty_req   = (width_in == '0) || (height_in == '0);
  assign scan_load   = accept && !empty_req;
  assign scan_enable = (state_reg == S_DRAW);

  raster_scanner #(
    .SIZE_W (SIZE_W)
  ) u_scanner (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (scan_load),
    .enable  (scan_enable),
    .w       (w_reg),
    .h       (h_reg),
    .ox      (ox),
    .oy      (oy),
    .last    (scan_last),
    .border  (scan_border)
  );

  assign px     = PX_W'(x_reg) + PX_W'(ox);
  assign py     = PY_W'(y_reg) + PY_W'(oy);
  assign pix_en = ((mode_reg == MODE_FILL) || scan_border) &&
                  (px < SCREEN_W_L) && (py < SCREEN_H_L);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      x_reg          <= '0;
      y_reg          <= '0;
      colour_reg     <= '0;
      w_reg          <= '0;
      h_reg          <= '0;
      mode_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      plot_reg       <= 1'b0;
      out_x_reg      <= '0;
      out_y_reg      <= '0;
      out_colour_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      plot_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            x_reg      <= x_in;
            y_reg      <= y_in;
            colour_reg <= colour_in;
            w_reg      <= width_in;
            h_reg      <= height_in;
            mode_reg   <= mode;
            busy_reg   <= 1'b1;
            state_reg  <= empty_req ? S_DONE : S_DRAW;
          end
        end
        S_DRAW: begin
          // Clipped or interior-outline positions still cost a cycle; the
          // coordinate outputs simply hold their last plotted value.
          plot_reg <= pix_en;
          if (pix_en) begin
            out_x_reg      <= px[X_W-1:0];
            out_y_reg      <= py[Y_W-1:0];
            out_colour_reg <= colour_reg;
          end
          if (scan_last) begin
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign plot       = plot_reg;
  assign out_x      = out_x_reg;
  assign out_y      = out_y_reg;
  assign out_colour = out_colour_reg;

endmodule

// File: tb/tb_box_drawer.sv
// Self-checking bench for box_drawer: directed boxes from the test plan plus
// random boxes, each checked cycle by cycle against a pixel-list model.
module tb_box_drawer;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic [3:0] width_in;
  logic [3:0] height_in;
  logic       mode;
  logic       busy;
  logic       done;
  logic       plot;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;

  int errors = 0;
  int checks = 0;
  int held_x = 0;
  int held_y = 0;
  int held_c = 0;

  box_drawer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .width_in   (width_in),
    .height_in  (height_in),
    .mode       (mode),
    .busy       (busy),
    .done       (done),
    .plot       (plot),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_colour (out_colour)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic scramble_inputs();
    x_in      = 8'($urandom);
    y_in      = 7'($urandom);
    colour_in = 3'($urandom);
    width_in  = 4'($urandom);
    height_in = 4'($urandom);
    mode      = 1'($urandom);
  endtask

  // Draws one box; poke_k>0 re-pulses start with junk inputs before scan edge poke_k.
  task automatic run_box(input string name, input int x, input int y, input int c,
                         input int w, input int h, input int m,
                         input int want_plots, input int poke_k);
    int total;
    int obs_plots;
    int s, ox, oy, px, py;
    bit en;
    total     = w * h;
    obs_plots = 0;
    x_in      = 8'(x);
    y_in      = 7'(y);
    colour_in = 3'(c);
    width_in  = 4'(w);
    height_in = 4'(h);
    mode      = 1'(m);
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    scramble_inputs();
    checks++;
    if (busy !== 1'b1 || plot !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: busy=%0b plot=%0b done=%0b required busy=1 plot=0 done=0",
               name, busy, plot, done);
    end
    for (int k = 1; k <= total; k++) begin
      if (k == poke_k) begin
        scramble_inputs();
        width_in  = 4'd1;
        height_in = 4'd1;
        start     = 1'b1;
      end
      @(posedge clock); #1;
      start = 1'b0;
      s  = k - 1;
      ox = s % w;
      oy = s / w;
      px = x + ox;
      py = y + oy;
      en = (m == 0 || ox == 0 || ox == w - 1 || oy == 0 || oy == h - 1) && px < 160 && py < 120;
      if (en) begin
        held_x = px;
        held_y = py;
        held_c = c;
      end
      if (plot === 1'b1) obs_plots++;
      checks++;
      if (plot !== en || out_x !== 8'(held_x) || out_y !== 7'(held_y) ||
          out_colour !== 3'(held_c) || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s scan%0d: plot=%0b x=%0d y=%0d c=%0d busy=%0b done=%0b required plot=%0b x=%0d y=%0d c=%0d busy=1 done=0",
                 name, k, plot, out_x, out_y, out_colour, busy, done, en, held_x, held_y, held_c);
      end
    end
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b1 || plot !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done: done=%0b plot=%0b busy=%0b required done=1 plot=0 busy=0",
               name, done, plot, busy);
    end
    if (want_plots >= 0) begin
      checks++;
      if (obs_plots != want_plots) begin
        errors++;
        $display("FAIL %s plot_count: got %0d required %0d", name, obs_plots, want_plots);
      end
    end
    $display("box %s at (%0d,%0d) %0dx%0d mode=%0d colour=%0d: %0d plots in %0d scan cycles",
             name, x, y, w, h, m, c, obs_plots, total);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        out_x !== 8'd0 || out_y !== 7'd0 || out_colour !== 3'd0) begin
      errors++;
      $display("FAIL %s: plot=%0b busy=%0b done=%0b x=%0d y=%0d c=%0d required all 0",
               name, plot, busy, done, out_x, out_y, out_colour);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    start     = 1'b0;
    x_in      = '0;
    y_in      = '0;
    colour_in = '0;
    width_in  = '0;
    height_in = '0;
    mode      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset_state");
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_all_zero("after_release");
    $display("reset: outputs idle");
  endtask

  task automatic test_directed();
    run_box("fill4x4", 10, 20, 5, 4, 4, 0, 16, 0);
    run_box("outline4x3", 0, 0, 6, 4, 3, 1, 10, 0);
    run_box("clip4x4", 158, 118, 3, 4, 4, 0, 4, 0);
    run_box("empty0x5", 30, 40, 2, 0, 5, 0, 0, 0);
  endtask

  task automatic test_restart_ignored();
    run_box("restart4x4", 50, 60, 4, 4, 4, 0, 16, 5);
  endtask

  task automatic test_reset_mid_draw();
    x_in      = 8'd70;
    y_in      = 7'd30;
    colour_in = 3'd7;
    width_in  = 4'd4;
    height_in = 4'd4;
    mode      = 1'b0;
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset_immediate");
    held_x = 0;
    held_y = 0;
    held_c = 0;
    @(posedge clock); #1;
    check_all_zero("mid_reset_held");
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check_all_zero("no_done_after_reset");
    end
    $display("mid-draw reset: block idle, no done");
    run_box("after_reset4x4", 70, 30, 7, 4, 4, 0, 16, 0);
  endtask

  task automatic test_random();
    int x, y, c, w, h, m;
    for (int i = 0; i < 8; i++) begin
      x = ($urandom_range(0, 1) == 1) ? int'($urandom_range(145, 170)) : int'($urandom_range(0, 255));
      y = ($urandom_range(0, 1) == 1) ? int'($urandom_range(108, 127)) : int'($urandom_range(0, 127));
      c = int'($urandom_range(0, 7));
      w = int'($urandom_range(0, 15));
      h = int'($urandom_range(0, 15));
      m = int'($urandom_range(0, 1));
      run_box($sformatf("rand%0d", i), x, y, c, w, h, m, -1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_restart_ignored();
    test_reset_mid_draw();
    test_random();
    @(posedge clock); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL final_idle: done=%0b busy=%0b required 0 0", done, busy);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
